// File: rtl/parser_seg_writer.sv
// parser_seg_writer: ingress segment writer. Forwards every accepted beat to
// the packet cache FIFO one cycle later and captures the first two 512-bit
// segments, the first beat's tuser and the VLAN ID into a one-entry header slot.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a packet's first beat (blocked while slot full)
// WAIT_SEG1 | first beat captured, waiting for the second beat
// FLUSH     | header complete, forwarding remaining beats up to tlast
module parser_seg_writer #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_VLANID_WIDTH     = 12,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]      pkt_fifo_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    pkt_fifo_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     pkt_fifo_tuser,
  output logic                              pkt_fifo_tlast,
  output logic                              pkt_fifo_wr_en,
  input  logic                              pkt_fifo_nearly_full,
  output logic [2*C_AXIS_DATA_WIDTH-1:0]    hdr_segs,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     hdr_tuser,
  output logic [C_VLANID_WIDTH-1:0]         vlan_id,
  output logic                              hdr_valid,
  input  logic                              hdr_ready,
  output logic [C_CNT_WIDTH-1:0]            pkt_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_SEG1, FLUSH} state_t;

  state_t                            state_q, state_d;
  logic [C_AXIS_DATA_WIDTH-1:0]      seg0_q, seg0_d;
  logic [C_AXIS_DATA_WIDTH-1:0]      seg1_q, seg1_d;
  logic [C_AXIS_TUSER_WIDTH-1:0]     hdr_tuser_q, hdr_tuser_d;
  logic [C_VLANID_WIDTH-1:0]         vlan_id_q, vlan_id_d;
  logic                              hdr_valid_q, hdr_valid_d;
  logic [C_CNT_WIDTH-1:0]            pkt_cnt_q, pkt_cnt_d;
  logic [C_AXIS_DATA_WIDTH-1:0]      fifo_tdata_q, fifo_tdata_d;
  logic [C_AXIS_DATA_WIDTH/8-1:0]    fifo_tkeep_q, fifo_tkeep_d;
  logic [C_AXIS_TUSER_WIDTH-1:0]     fifo_tuser_q, fifo_tuser_d;
  logic                              fifo_tlast_q, fifo_tlast_d;
  logic                              fifo_wr_en_q, fifo_wr_en_d;
  logic                              tready_c;
  logic                              hs;

  // Ready depends only on state, FIFO fill and slot occupancy (never on tvalid);
  // gated by aresetn so nothing is accepted while reset is held.
  always_comb begin
    tready_c = 1'b0;
    case (state_q)
      IDLE:    tready_c = ~pkt_fifo_nearly_full & ~hdr_valid_q;
      default: tready_c = ~pkt_fifo_nearly_full;
    endcase
    tready_c = tready_c & aresetn;
  end

  assign hs = s_axis_tvalid & tready_c;

  // Next-state: FIFO write path, header capture and slot/counter handshake.
  always_comb begin
    state_d      = state_q;
    seg0_d       = seg0_q;
    seg1_d       = seg1_q;
    hdr_tuser_d  = hdr_tuser_q;
    vlan_id_d    = vlan_id_q;
    hdr_valid_d  = hdr_valid_q;
    pkt_cnt_d    = pkt_cnt_q;
    fifo_tdata_d = fifo_tdata_q;
    fifo_tkeep_d = fifo_tkeep_q;
    fifo_tuser_d = fifo_tuser_q;
    fifo_tlast_d = fifo_tlast_q;
    fifo_wr_en_d = hs;

    if (hs) begin
      fifo_tdata_d = s_axis_tdata;
      fifo_tkeep_d = s_axis_tkeep;
      fifo_tuser_d = s_axis_tuser;
      fifo_tlast_d = s_axis_tlast;
    end

    // Slot can only be refilled from IDLE/WAIT_SEG1, both of which imply it
    // is empty, so the clear below never collides with a set.
    if (hdr_valid_q && hdr_ready) begin
      hdr_valid_d = 1'b0;
      pkt_cnt_d   = pkt_cnt_q + {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    case (state_q)
      IDLE: begin
        if (hs) begin
          seg0_d      = s_axis_tdata;
          hdr_tuser_d = s_axis_tuser;
          vlan_id_d   = {s_axis_tdata[115:112], s_axis_tdata[127:120]};
          if (s_axis_tlast) begin
            seg1_d      = '0;
            hdr_valid_d = 1'b1;
          end else begin
            state_d = WAIT_SEG1;
          end
        end
      end
      WAIT_SEG1: begin
        if (hs) begin
          seg1_d      = s_axis_tdata;
          hdr_valid_d = 1'b1;
          state_d     = s_axis_tlast ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        if (hs && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All registers clear asynchronously; a partial header is simply dropped.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      seg0_q       <= '0;
      seg1_q       <= '0;
      hdr_tuser_q  <= '0;
      vlan_id_q    <= '0;
      hdr_valid_q  <= 1'b0;
      pkt_cnt_q    <= '0;
      fifo_tdata_q <= '0;
      fifo_tkeep_q <= '0;
      fifo_tuser_q <= '0;
      fifo_tlast_q <= 1'b0;
      fifo_wr_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg0_q       <= seg0_d;
      seg1_q       <= seg1_d;
      hdr_tuser_q  <= hdr_tuser_d;
      vlan_id_q    <= vlan_id_d;
      hdr_valid_q  <= hdr_valid_d;
      pkt_cnt_q    <= pkt_cnt_d;
      fifo_tdata_q <= fifo_tdata_d;
      fifo_tkeep_q <= fifo_tkeep_d;
      fifo_tuser_q <= fifo_tuser_d;
      fifo_tlast_q <= fifo_tlast_d;
      fifo_wr_en_q <= fifo_wr_en_d;
    end
  end

  assign s_axis_tready  = tready_c;
  assign pkt_fifo_tdata = fifo_tdata_q;
  assign pkt_fifo_tkeep = fifo_tkeep_q;
  assign pkt_fifo_tuser = fifo_tuser_q;
  assign pkt_fifo_tlast = fifo_tlast_q;
  assign pkt_fifo_wr_en = fifo_wr_en_q;
  assign hdr_segs       = {seg1_q, seg0_q};
  assign hdr_tuser      = hdr_tuser_q;
  assign vlan_id        = vlan_id_q;
  assign hdr_valid      = hdr_valid_q;
  assign pkt_cnt        = pkt_cnt_q;

endmodule

// File: tb/tb_parser_seg_writer.sv
// Bench for parser_seg_writer: packet-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_parser_seg_writer;

  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           aresetn = 1'b0;
  logic [511:0]   s_axis_tdata = '0;
  logic [63:0]    s_axis_tkeep = '0;
  logic [127:0]   s_axis_tuser = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tlast = 1'b0;
  logic           s_axis_tready;
  logic [511:0]   pkt_fifo_tdata;
  logic [63:0]    pkt_fifo_tkeep;
  logic [127:0]   pkt_fifo_tuser;
  logic           pkt_fifo_tlast;
  logic           pkt_fifo_wr_en;
  logic           pkt_fifo_nearly_full = 1'b0;
  logic [1023:0]  hdr_segs;
  logic [127:0]   hdr_tuser;
  logic [11:0]    vlan_id;
  logic           hdr_valid;
  logic           hdr_ready = 1'b0;
  logic [CW-1:0]  pkt_cnt;

  parser_seg_writer #(.C_CNT_WIDTH(CW)) dut (
    .axis_clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .pkt_fifo_tdata(pkt_fifo_tdata), .pkt_fifo_tkeep(pkt_fifo_tkeep), .pkt_fifo_tuser(pkt_fifo_tuser),
    .pkt_fifo_tlast(pkt_fifo_tlast), .pkt_fifo_wr_en(pkt_fifo_wr_en),
    .pkt_fifo_nearly_full(pkt_fifo_nearly_full),
    .hdr_segs(hdr_segs), .hdr_tuser(hdr_tuser), .vlan_id(vlan_id),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int last_count = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // Reference model: what the outputs must be after the coming edge.
  logic         m_wr = 1'b0;
  logic [511:0] m_d = '0;
  logic [63:0]  m_k = '0;
  logic [127:0] m_u = '0;
  logic         m_l = 1'b0;
  logic         m_hv = 1'b0;
  logic [511:0] m_seg0 = '0, m_seg1 = '0, p_seg0 = '0;
  logic [127:0] m_tu = '0, p_tu = '0;
  logic [11:0]  m_vid = '0, p_vid = '0;
  int           m_cnt = 0;
  int           m_idx = 0;

  always @(negedge clk) begin
    logic exp_rdy;
    logic hs;
    if (pkt_fifo_wr_en) wr_count++;
    if (pkt_fifo_wr_en && pkt_fifo_tlast) last_count++;
    if (!aresetn) begin
      m_wr = 0; m_hv = 0; m_cnt = 0; m_idx = 0;
      chk("rst_hdr_valid", 512'(hdr_valid), 0);
      chk("rst_wr_en", 512'(pkt_fifo_wr_en), 0);
      chk("rst_tready", 512'(s_axis_tready), 0);
      chk("rst_pkt_cnt", 512'(pkt_cnt), 0);
    end else begin
      chk("wr_en", 512'(pkt_fifo_wr_en), 512'(m_wr));
      if (m_wr) begin
        chk("fifo_tdata", pkt_fifo_tdata, m_d);
        chk("fifo_tkeep", 512'(pkt_fifo_tkeep), 512'(m_k));
        chk("fifo_tuser", 512'(pkt_fifo_tuser), 512'(m_u));
        chk("fifo_tlast", 512'(pkt_fifo_tlast), 512'(m_l));
      end
      chk("hdr_valid", 512'(hdr_valid), 512'(m_hv));
      if (m_hv) begin
        chk("seg0", hdr_segs[511:0], m_seg0);
        chk("seg1", hdr_segs[1023:512], m_seg1);
        chk("hdr_tuser", 512'(hdr_tuser), 512'(m_tu));
        chk("vlan_id", 512'(vlan_id), 512'(m_vid));
      end
      chk("pkt_cnt", 512'(pkt_cnt), 512'(m_cnt % (1 << CW)));
      // A first beat waits for an empty header slot; later beats only for FIFO room.
      exp_rdy = !pkt_fifo_nearly_full && !(m_idx == 0 && m_hv);
      chk("tready", 512'(s_axis_tready), 512'(exp_rdy));
      hs = s_axis_tvalid && exp_rdy;
      m_wr = hs;
      if (hs) begin
        m_d = s_axis_tdata; m_k = s_axis_tkeep; m_u = s_axis_tuser; m_l = s_axis_tlast;
      end
      if (m_hv && hdr_ready) begin
        m_hv = 0;
        m_cnt++;
      end
      if (hs) begin
        if (m_idx == 0) begin
          p_seg0 = s_axis_tdata;
          p_tu   = s_axis_tuser;
          p_vid  = {s_axis_tdata[115:112], s_axis_tdata[127:120]};
          if (s_axis_tlast) begin
            m_seg0 = p_seg0; m_seg1 = '0; m_tu = p_tu; m_vid = p_vid; m_hv = 1;
          end
        end else if (m_idx == 1) begin
          m_seg0 = p_seg0; m_seg1 = s_axis_tdata; m_tu = p_tu; m_vid = p_vid; m_hv = 1;
        end
        m_idx = s_axis_tlast ? 0 : m_idx + 1;
      end
    end
  end

  task automatic send_pkt(input int n, input logic [7:0] base, input logic [11:0] vid,
                          input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      int t;
      logic [511:0] d;
      t = 0;
      d = '0;
      d[7:0]     = base + 8'(i);
      d[127:120] = vid[7:0];
      d[115:112] = vid[11:8];
      d[511:504] = ~(base + 8'(i));
      s_axis_tdata  = d;
      s_axis_tkeep  = (i == 2) ? 64'h0 : ({64{1'b1}} >> i);
      s_axis_tuser  = {base, 112'h0, 8'(i)};
      s_axis_tlast  = last_at_end && (i == n - 1);
      s_axis_tvalid = 1'b1;
      do begin
        @(negedge clk);
        t++;
      end while (!s_axis_tready && t < 200);
      if (!s_axis_tready) fail("beat_accept");
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_hv();
    int t;
    t = 0;
    while (!hdr_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!hdr_valid) fail("hdr_valid_wait");
  endtask

  task automatic pulse_ready();
    hdr_ready = 1'b1;
    @(posedge clk); #1;
    hdr_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  initial begin
    int w0, l0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single-beat packet
    send_pkt(1, 8'h10, 12'h123, 1);
    chk("sb_hdr_valid", 512'(hdr_valid), 1);
    chk("sb_vlan", 512'(vlan_id), 512'h123);
    chk("sb_seg1_zero", hdr_segs[1023:512], 0);
    chk("sb_fifo_last", 512'({pkt_fifo_wr_en, pkt_fifo_tlast}), 512'h3);
    pulse_ready();
    chk("sb_pkt_cnt", 512'(pkt_cnt), 1);
    chk("sb_hdr_clear", 512'(hdr_valid), 0);

    // Four-beat packet with hdr_ready held high; beat 2 has tkeep = 0
    w0 = wr_count; l0 = last_count;
    hdr_ready = 1'b1;
    send_pkt(4, 8'h0A, 12'h456, 1);
    repeat (2) @(posedge clk); #1;
    hdr_ready = 1'b0;
    chk("fb_seg0_b", 512'(hdr_segs[7:0]), 512'h0A);
    chk("fb_seg1_b", 512'(hdr_segs[519:512]), 512'h0B);
    chk("fb_vlan", 512'(vlan_id), 512'h456);
    chk("fb_writes", 512'(wr_count - w0), 4);
    chk("fb_lasts", 512'(last_count - l0), 1);
    chk("fb_pkt_cnt", 512'(pkt_cnt), 2);

    // Header back-pressure: two 2-beat packets with hdr_ready low
    fork
      begin
        send_pkt(2, 8'h30, 12'h0AB, 1);
        send_pkt(2, 8'h40, 12'h0CD, 1);
      end
      begin
        wait_hv();
        repeat (4) @(posedge clk); #1;
        chk("bp_stalled", 512'(s_axis_tready), 0);
        chk("bp_hdr1", 512'(hdr_segs[7:0]), 512'h30);
        pulse_ready();
        chk("bp_hv_fell", 512'(hdr_valid), 0);
        wait_hv();
        chk("bp_hdr2", 512'(hdr_segs[7:0]), 512'h40);
        chk("bp_hdr2_seg1", 512'(hdr_segs[519:512]), 512'h41);
        pulse_ready();
      end
    join
    chk("bp_pkt_cnt", 512'(pkt_cnt), 4);

    // FIFO back-pressure for 5 cycles mid-packet
    w0 = wr_count;
    hdr_ready = 1'b1;
    fork
      send_pkt(6, 8'h70, 12'h777, 1);
      begin
        repeat (3) @(posedge clk); #1;
        pkt_fifo_nearly_full = 1'b1;
        repeat (5) @(posedge clk); #1;
        pkt_fifo_nearly_full = 1'b0;
      end
    join
    repeat (2) @(posedge clk); #1;
    hdr_ready = 1'b0;
    chk("fnf_writes", 512'(wr_count - w0), 6);

    // Reset while waiting for the second segment
    send_pkt(1, 8'h50, 12'h555, 0);
    #1 aresetn = 1'b0;
    #1;
    chk("ar_hdr_valid", 512'(hdr_valid), 0);
    chk("ar_wr_en", 512'(pkt_fifo_wr_en), 0);
    chk("ar_tready", 512'(s_axis_tready), 0);
    chk("ar_pkt_cnt", 512'(pkt_cnt), 0);
    chk("ar_seg0", hdr_segs[511:0], 0);
    chk("ar_fifo_tdata", pkt_fifo_tdata, 0);
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    send_pkt(2, 8'h60, 12'h321, 1);
    wait_hv();
    chk("ar_new_seg0", 512'(hdr_segs[7:0]), 512'h60);
    chk("ar_new_seg0_top", 512'(hdr_segs[511:504]), 512'h9F);
    chk("ar_new_seg1", 512'(hdr_segs[519:512]), 512'h61);
    chk("ar_new_vlan", 512'(vlan_id), 512'h321);
    pulse_ready();

    // Counter wrap with a 4-bit counter: 17 packets leaves 1
    do_reset();
    hdr_ready = 1'b1;
    for (int p = 0; p < 17; p++) send_pkt(1, 8'(p), 12'(p), 1);
    repeat (3) @(posedge clk); #1;
    hdr_ready = 1'b0;
    chk("wrap_pkt_cnt", 512'(pkt_cnt), 1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/parser_seg_writer.md
# parser_seg_writer

Ingress-side segment writer for the RMT pipeline: accepts the 512-bit AXI-Stream packet entering the parser, stores every beat in the packet cache FIFO and extracts the first two segments (1024 bits) plus the 12-bit VLAN ID into a one-entry header slot for PHV extraction. It is the write-side counterpart of the deparser's packet-FIFO/VLAN-FIFO read path. Every beat is forwarded unmodified, so the deparser can later re-merge the PHV with the stored segments.

## Interface
- C_AXIS_DATA_WIDTH, 512, stream data width; fixed to 512 in this block.
- C_AXIS_TUSER_WIDTH, 128, tuser width.
- C_VLANID_WIDTH, 12, VLAN ID width.
- C_CNT_WIDTH, 32, width of the packet counter.
- axis_clk  in  1  single clock for all logic.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata / s_axis_tkeep / s_axis_tuser  in  512 / 64 / 128  ingress beat.
- s_axis_tvalid, s_axis_tlast  in  1  ingress valid and last.
- s_axis_tready  out  1  ingress ready.
- pkt_fifo_tdata / pkt_fifo_tkeep / pkt_fifo_tuser  out  512 / 64 / 128  registered beat for the packet cache FIFO.
- pkt_fifo_tlast, pkt_fifo_wr_en  out  1  registered last and write strobe.
- pkt_fifo_nearly_full  in  1  back-pressure from the packet cache FIFO.
- hdr_segs  out  1024  {seg1, seg0}; seg0 is in [511:0].
- hdr_tuser  out  128  tuser of the first beat.
- vlan_id  out  12  VLAN ID of the packet.
- hdr_valid  out  1  header slot full.
- hdr_ready  in  1  the consumer takes the header slot.
- pkt_cnt  out  C_CNT_WIDTH  count of packets whose header has been emitted.

## Operation
- The state machine has three states: IDLE, WAIT_SEG1 and FLUSH.
- IDLE:
  - s_axis_tready = ~pkt_fifo_nearly_full & ~hdr_valid.
  - On a handshake, capture seg0 = tdata, hdr_tuser = tuser and vlan_id = {tdata[115:112], tdata[127:120]}.
  - If tlast is set: seg1 = 0, set hdr_valid, stay in IDLE.
  - Otherwise go to WAIT_SEG1.
- WAIT_SEG1:
  - s_axis_tready = ~pkt_fifo_nearly_full.
  - On a handshake, capture seg1 = tdata and set hdr_valid.
  - Go to IDLE if tlast is set, otherwise to FLUSH.
- FLUSH:
  - s_axis_tready = ~pkt_fifo_nearly_full.
  - On a handshake with tlast, go to IDLE.
- Every accepted beat, in any state, is written to the packet FIFO with tdata, tkeep, tuser and tlast unmodified.
- Header slot:
  - hdr_valid is held, with hdr_segs, hdr_tuser and vlan_id stable, until hdr_valid & hdr_ready. It clears on the next edge.
  - pkt_cnt increments on that same edge and wraps from 2^C_CNT_WIDTH-1 to 0.
- hdr_ready is ignored while hdr_valid is 0.
- A valid beat with tkeep = 0 is still written.

## Timing
- Reset values: all state registers, hdr_segs, hdr_tuser, vlan_id and pkt_cnt are 0; all pkt_fifo_* outputs are 0; the state is IDLE. Consequently hdr_valid = 0, pkt_fifo_wr_en = 0 and s_axis_tready = 0 while aresetn is low.
- pkt_fifo_wr_en and pkt_fifo_* data appear exactly 1 cycle after the s_axis handshake.
- hdr_valid rises 1 cycle after the handshake of the header-completing beat: the second beat, or a single-beat packet.
- The header is never emitted before its packet's beats are written: hdr_valid rises on the same edge as that beat's pkt_fifo_wr_en.
- s_axis_tready is combinational from the state, pkt_fifo_nearly_full and hdr_valid. No combinational path from tvalid to tready.
- Simultaneous hdr_valid & hdr_ready and a new first beat:
  - The new first beat is not accepted in that cycle, because tready used hdr_valid = 1.
  - It is accepted the following cycle, giving a 1-bubble minimum between headers.
- Throughput: one beat per cycle in WAIT_SEG1 and FLUSH while the FIFO is not nearly full.
- pkt_fifo_nearly_full must leave at least 1 spare entry, covering the registered write in flight.
- Reset during a packet:
  - The state returns to IDLE and the partial header is discarded.
  - Beats already written are not retracted; the system resets the packet FIFO with the same aresetn.

## Test plan
- **Single-beat packet:** tdata[127:120]=0x23, tdata[115:112]=0x1, tlast=1.
  - vlan_id=0x123, hdr_segs[1023:512]=0.
  - 1 FIFO write with tlast=1.
  - hdr_valid 1 cycle after the handshake; pkt_cnt=1 after hdr_ready.
- **Four-beat packet, beats 0xA..0xD in tdata[7:0], hdr_ready held high:**
  - hdr_segs[7:0]=0xA, hdr_segs[519:512]=0xB.
  - 4 FIFO writes, each 1 cycle after its handshake.
  - tlast only on the 4th write.
- **Header back-pressure:** hdr_ready=0 with two 2-beat packets sent back to back.
  - The second packet's first beat is stalled (tready=0) until hdr_ready pulses.
  - The second packet is then accepted 1 cycle after hdr_valid falls.
- **FIFO back-pressure:** pkt_fifo_nearly_full asserted mid-packet for 5 cycles.
  - tready=0 for those 5 cycles; no pkt_fifo_wr_en.
  - No beats are lost or duplicated; the FIFO write sequence equals the input sequence.
- **Reset mid-packet:** aresetn deasserted asynchronously in WAIT_SEG1.
  - All outputs are 0 immediately.
  - After release, a new 2-beat packet produces a correct header, with no stale seg0.
- **Counter wrap:** C_CNT_WIDTH=4, 17 single-beat packets consumed → pkt_cnt=1.
